operand_issue_stage: RTL and testbench
======================================

// Module: operand_issue_stage
// PURPOSE
//  Decode-to-execute pipeline register that sits between the register file and the EX stage.
//  Captures decoded control, combines RF read data with bypass data from EX/MEM and WB, and
//  detects load-use hazards. Uses a valid/ready handshake in both directions.
//  Counts hazard-stall cycles for performance monitoring.
// PARAMETERS
//  CTRL_W   12  width of the opaque decoded-control bundle passed through to EX
//  CNT_W    16  width of the saturating stall counter
// PORTS
//  clk            in   1      rising-edge clock
//  reset          in   1      asynchronous, active-low reset
//  in_valid       in   1      decode presents an instruction
//  in_ready       out  1      stage accepts (in_valid & in_ready = transfer)
//  in_rs1,in_rs2  in   5      source register indices; these also drive the RF A1/A2 inputs
//  in_rd          in   5      destination index
//  in_rd_we       in   1      instruction writes in_rd
//  in_is_load     in   1      instruction is a load
//  in_ctrl        in   CTRL_W decoded control bundle
//  in_imm,in_pc   in   32     immediate, PC
//  rf_rd1,rf_rd2  in   32     RF combinational read data for in_rs1/in_rs2
//  mem_valid      in   1      EX/MEM register holds a valid instruction
//  mem_rd_we      in   1      that instruction writes a register
//  mem_rd         in   5      its destination
//  mem_is_load    in   1      it is a load (data not yet available)
//  mem_data       in   32     its ALU result
//  wb_we,wb_rd    in   1,5    same signals that drive RF WE3/A3
//  wb_data        in   32     same signal that drives RF WD3
//  flush          in   1      branch/trap kill of this stage and of the incoming instruction
//  out_valid      out  1      EX-bound instruction valid
//  out_ready      in   1      EX accepts
//  out_rs1_val,out_rs2_val out 32  resolved operands
//  out_rd,out_rd_we,out_is_load,out_ctrl,out_imm,out_pc  out  registered copies
//  stall_count    out  CNT_W  saturating count of hazard-stall cycles
// BEHAVIOUR
//  Reset (reset=0, async): out_valid=0; every out_* data field =0; stall_count=0.
//   in_ready is 0 during reset and is combinational afterwards.
//  States: EMPTY (out_valid=0) and FULL (out_valid=1). Single entry, no skip path.
//   Latency is 1 cycle from an accepted input to out_valid.
//  Operand resolution, per source s in {rs1, rs2}, combinational, first match wins:
//   s==0 -> 0;
//   mem_valid&mem_rd_we&!mem_is_load&mem_rd==s -> mem_data;
//   wb_we&wb_rd==s -> wb_data (bypasses the same-edge RF write);
//   otherwise rf_rdN.
//  hazard = in_valid & a source s!=0 matches either of:
//   (a) FULL & out_rd_we & out_is_load & out_rd==s
//   (b) mem_valid & mem_rd_we & mem_is_load & mem_rd==s
//  in_ready = (EMPTY | out_ready) & !hazard & !flush.
//  Each clock edge, in priority order:
//   1) flush: out_valid<=0; the incoming instruction is dropped; stall_count unchanged.
//   2) accept (in_valid&in_ready): load all out_* with resolved operands; out_valid<=1.
//   3) FULL & out_ready & no accept: out_valid<=0 (this is a bubble when hazard is set).
//   4) otherwise hold; all out_* stay stable while out_valid & !out_ready.
//  stall_count increments on each edge with hazard & !flush and saturates at all-ones.
//  Writes to index 0 (wb or mem) are never forwarded. Simultaneous mem and wb matches
//   resolve to mem_data.
//  Reset asserted mid-transfer: the in-flight instruction is lost; EX must be reset too.
// TESTING
//  1 RF path: x5=0x11 in RF, no bypass; issue rs1=5 -> out_rs1_val=0x11 one cycle after accept.
//  2 WB bypass: wb_we=1,wb_rd=7,wb_data=0xABCD with rf_rd2=old while in_rs2=7 ->
//    out_rs2_val=0xABCD. Also mem_rd=7 with mem_data=0x1234 in the same cycle -> 0x1234.
//  3 Load-use: issue lw x3, then add rs1=3 -> in_ready=0 for 2 cycles; bubble (out_valid=0) reaches EX;
//    add issues with out_rs1_val=wb_data; stall_count=2.
//  4 Backpressure: FULL with out_ready=0 for 4 cycles -> outputs stable, in_ready=0;
//    out_ready=1 with in_valid=1 -> back-to-back transfer.
//  5 Flush: flush=1 while FULL and in_valid=1 -> next cycle out_valid=0, no accept;
//    rd=0 forwarding: wb_rd=0,wb_data=0xFF, in_rs1=0 -> operand 0.
//  6 Reset: drop reset low mid-stream -> out_valid=0 immediately (async); stall_count saturates at 0xFFFF.

Source files
------------

// File: rtl/operand_issue_stage.sv
// Decode-to-execute pipeline register. Resolves operands from RF/EX-MEM/WB,
// stalls on load-use hazards and counts stall cycles (saturating).
module operand_issue_stage #(
    parameter int CTRL_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic              in_rd_we,
    input  logic              in_is_load,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [31:0]       in_imm,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       rf_rd1,
    input  logic [31:0]       rf_rd2,
    input  logic              mem_valid,
    input  logic              mem_rd_we,
    input  logic [4:0]        mem_rd,
    input  logic              mem_is_load,
    input  logic [31:0]       mem_data,
    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [31:0]       wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_rs1_val,
    output logic [31:0]       out_rs2_val,
    output logic [4:0]        out_rd,
    output logic              out_rd_we,
    output logic              out_is_load,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [31:0]       out_imm,
    output logic [31:0]       out_pc,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state_reg;

    logic [1:0][4:0]  src_idx;
    logic [1:0][31:0] src_rf;
    logic [1:0][31:0] src_val;
    logic [1:0]       src_hazard;

    logic mem_fwd_ok;
    logic mem_load_pending;
    logic full_load_pending;
    logic hazard;
    logic accept;

    assign src_idx = {in_rs2, in_rs1};
    assign src_rf  = {rf_rd2, rf_rd1};

    // A load in EX/MEM has no data yet, so it can only stall, never forward.
    assign mem_fwd_ok        = mem_valid & mem_rd_we & ~mem_is_load;
    assign mem_load_pending  = mem_valid & mem_rd_we & mem_is_load;
    assign full_load_pending = (state_reg == FULL) & out_rd_we & out_is_load;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic is_zero;
            logic mem_hit;
            logic wb_hit;

            assign is_zero = (src_idx[gi] == 5'd0);
            assign mem_hit = mem_fwd_ok & (mem_rd == src_idx[gi]);
            assign wb_hit  = wb_we & (wb_rd == src_idx[gi]);

            // Youngest producer wins; x0 is hardwired regardless of any bypass.
            assign src_val[gi] = is_zero ? 32'd0     :
                                 mem_hit ? mem_data  :
                                 wb_hit  ? wb_data   :
                                           src_rf[gi];

            assign src_hazard[gi] = ~is_zero &
                                    ((full_load_pending & (out_rd == src_idx[gi])) |
                                     (mem_load_pending  & (mem_rd == src_idx[gi])));
        end
    endgenerate

    assign hazard    = in_valid & (|src_hazard);
    assign in_ready  = reset & ((state_reg == EMPTY) | out_ready) & ~hazard & ~flush;
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_reg == FULL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= EMPTY;
            out_rs1_val <= '0;
            out_rs2_val <= '0;
            out_rd      <= '0;
            out_rd_we   <= 1'b0;
            out_is_load <= 1'b0;
            out_ctrl    <= '0;
            out_imm     <= '0;
            out_pc      <= '0;
            stall_count <= '0;
        end else begin
            if (hazard && !flush && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + CNT_W'(1);
            end

            if (flush) begin
                state_reg <= EMPTY;
            end else if (accept) begin
                state_reg   <= FULL;
                out_rs1_val <= src_val[0];
                out_rs2_val <= src_val[1];
                out_rd      <= in_rd;
                out_rd_we   <= in_rd_we;
                out_is_load <= in_is_load;
                out_ctrl    <= in_ctrl;
                out_imm     <= in_imm;
                out_pc      <= in_pc;
            end else if ((state_reg == FULL) && out_ready) begin
                state_reg <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_operand_issue_stage.sv
// Self-checking bench for operand_issue_stage: directed scenarios plus random
// traffic compared against a behavioural model of the issue stage.
module tb_operand_issue_stage;
    localparam int CTRL_W = 12;
    localparam int CNT_W  = 16;
    localparam int BUS_W  = 32 + 32 + 5 + 1 + 1 + CTRL_W + 32 + 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid, in_ready;
    logic [4:0]        in_rs1, in_rs2, in_rd;
    logic              in_rd_we, in_is_load;
    logic [CTRL_W-1:0] in_ctrl;
    logic [31:0]       in_imm, in_pc;
    logic [31:0]       rf_rd1, rf_rd2;
    logic              mem_valid, mem_rd_we, mem_is_load;
    logic [4:0]        mem_rd;
    logic [31:0]       mem_data;
    logic              wb_we;
    logic [4:0]        wb_rd;
    logic [31:0]       wb_data;
    logic              flush;
    logic              out_valid, out_ready;
    logic [31:0]       out_rs1_val, out_rs2_val;
    logic [4:0]        out_rd;
    logic              out_rd_we, out_is_load;
    logic [CTRL_W-1:0] out_ctrl;
    logic [31:0]       out_imm, out_pc;
    logic [CNT_W-1:0]  stall_count;

    always #5 clk = ~clk;

    // Register file seen by the stage; written one edge after a WB write.
    logic [31:0] rf_mem [32];
    assign rf_rd1 = rf_mem[in_rs1];
    assign rf_rd2 = rf_mem[in_rs2];

    operand_issue_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_rd_we(in_rd_we), .in_is_load(in_is_load), .in_ctrl(in_ctrl),
        .in_imm(in_imm), .in_pc(in_pc),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .mem_valid(mem_valid), .mem_rd_we(mem_rd_we), .mem_rd(mem_rd),
        .mem_is_load(mem_is_load), .mem_data(mem_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_rd(out_rd), .out_rd_we(out_rd_we), .out_is_load(out_is_load),
        .out_ctrl(out_ctrl), .out_imm(out_imm), .out_pc(out_pc),
        .stall_count(stall_count)
    );

    int checks = 0;
    int failures = 0;

    // Behavioural model of the single-entry stage
    bit                m_valid;
    logic [31:0]       m_rs1_val, m_rs2_val, m_imm, m_pc;
    logic [4:0]        m_rd;
    bit                m_rd_we, m_is_load;
    logic [CTRL_W-1:0] m_ctrl;
    longint            stall_events;
    bit                exp_ready;
    logic              obs_ready;

    function automatic logic [31:0] resolve(input logic [4:0] s);
        if (s == 5'd0) return 32'd0;
        if (mem_valid && mem_rd_we && !mem_is_load && mem_rd == s) return mem_data;
        if (wb_we && wb_rd == s) return wb_data;
        return rf_mem[s];
    endfunction

    function automatic bit load_blocks(input logic [4:0] s);
        if (s == 5'd0) return 1'b0;
        if (m_valid && m_rd_we && m_is_load && m_rd == s) return 1'b1;
        if (mem_valid && mem_rd_we && mem_is_load && mem_rd == s) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [CNT_W-1:0] exp_stall();
        return (stall_events >= 65535) ? 16'hFFFF : 16'(stall_events);
    endfunction

    function automatic logic [BUS_W-1:0] exp_bus();
        return {m_rs1_val, m_rs2_val, m_rd, m_rd_we, m_is_load, m_ctrl, m_imm, m_pc};
    endfunction

    function automatic logic [BUS_W-1:0] obs_bus();
        return {out_rs1_val, out_rs2_val, out_rd, out_rd_we, out_is_load, out_ctrl, out_imm, out_pc};
    endfunction

    task automatic reset_model();
        m_valid = 0; m_rs1_val = 0; m_rs2_val = 0; m_imm = 0; m_pc = 0;
        m_rd = 0; m_rd_we = 0; m_is_load = 0; m_ctrl = 0; stall_events = 0;
    endtask

    // Advance one clock: evaluate the model on the settled inputs, then
    // return at posedge+1 with the model holding the post-edge state.
    task automatic tick();
        bit          hz, acc, do_wb;
        logic [4:0]  w_rd;
        logic [31:0] w_data;
        #1;
        hz = in_valid && (load_blocks(in_rs1) || load_blocks(in_rs2));
        exp_ready = (!m_valid || out_ready) && !hz && !flush;
        obs_ready = in_ready;
        acc = in_valid && exp_ready;
        do_wb = wb_we && (wb_rd != 5'd0);
        w_rd = wb_rd;
        w_data = wb_data;
        if (hz && !flush) stall_events++;
        if (flush) begin
            m_valid = 0;
        end else if (acc) begin
            m_valid = 1;
            m_rs1_val = resolve(in_rs1);
            m_rs2_val = resolve(in_rs2);
            m_rd = in_rd; m_rd_we = in_rd_we; m_is_load = in_is_load;
            m_ctrl = in_ctrl; m_imm = in_imm; m_pc = in_pc;
        end else if (out_ready) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        if (do_wb) rf_mem[w_rd] = w_data;
    endtask

    task automatic idle_side();
        mem_valid = 0; mem_rd_we = 0; mem_is_load = 0; mem_rd = 0; mem_data = 0;
        wb_we = 0; wb_rd = 0; wb_data = 0; flush = 0;
    endtask

    task automatic set_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input bit rd_we, input bit is_load, input logic [31:0] pc);
        in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_rd_we = rd_we; in_is_load = is_load;
        in_ctrl = CTRL_W'($urandom); in_imm = $urandom; in_pc = pc;
    endtask

    task automatic rand_inputs(input int flush_pct);
        in_valid    = ($urandom_range(0, 3) != 0);
        in_rs1      = 5'($urandom_range(0, 4));
        in_rs2      = 5'($urandom_range(0, 4));
        in_rd       = 5'($urandom_range(0, 4));
        in_rd_we    = 1'($urandom);
        in_is_load  = ($urandom_range(0, 2) == 0);
        in_ctrl     = CTRL_W'($urandom);
        in_imm      = $urandom;
        in_pc       = $urandom;
        mem_valid   = 1'($urandom);
        mem_rd_we   = 1'($urandom);
        mem_rd      = 5'($urandom_range(0, 4));
        mem_is_load = ($urandom_range(0, 3) == 0);
        mem_data    = $urandom;
        wb_we       = 1'($urandom);
        wb_rd       = 5'($urandom_range(0, 4));
        wb_data     = $urandom;
        flush       = ($urandom_range(0, 99) < flush_pct);
        out_ready   = ($urandom_range(0, 3) != 0);
    endtask

    task automatic test_reset();
        reset = 0;
        idle_side();
        set_instr(5'd1, 5'd2, 5'd3, 1, 0, 32'h10);
        out_ready = 1;
        #3;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++;
        if (stall_count !== 16'd0) begin failures++; $display("FAIL reset_stall_count: got %h expected 0", stall_count); end
        checks++;
        if (obs_bus() !== '0) begin failures++; $display("FAIL reset_out_fields: got %h expected 0", obs_bus()); end
        #9;
        reset = 1;
        in_valid = 0;
        reset_model();
        @(posedge clk);
        #1;
        $display("test_reset done");
    endtask

    task automatic test_rf_path();
        rf_mem[5] = 32'h11;
        idle_side();
        out_ready = 1;
        set_instr(5'd5, 5'd0, 5'd1, 1, 0, 32'h100);
        tick();
        checks++;
        if (obs_ready !== 1'b1) begin failures++; $display("FAIL rf_in_ready: got %b expected 1", obs_ready); end
        checks++;
        if (out_valid !== 1'b1 || out_rs1_val !== 32'h11 || out_rs2_val !== 32'h0)
            begin failures++; $display("FAIL rf_path: got v=%b rs1=%h rs2=%h expected v=1 rs1=00000011 rs2=0", out_valid, out_rs1_val, out_rs2_val); end
        in_valid = 0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rf_drain: got %b expected 0", out_valid); end
        $display("test_rf_path done");
    endtask

    task automatic test_bypass();
        rf_mem[7] = 32'h5555_5555;
        idle_side();
        out_ready = 1;
        wb_we = 1; wb_rd = 5'd7; wb_data = 32'hABCD;
        set_instr(5'd0, 5'd7, 5'd2, 1, 0, 32'h104);
        tick();
        checks++;
        if (out_rs2_val !== 32'hABCD) begin failures++; $display("FAIL wb_bypass: got %h expected 0000abcd", out_rs2_val); end
        rf_mem[7] = 32'h5555_5555;
        mem_valid = 1; mem_rd_we = 1; mem_is_load = 0; mem_rd = 5'd7; mem_data = 32'h1234;
        set_instr(5'd7, 5'd7, 5'd2, 1, 0, 32'h108);
        tick();
        checks++;
        if (out_rs1_val !== 32'h1234 || out_rs2_val !== 32'h1234)
            begin failures++; $display("FAIL mem_over_wb: got rs1=%h rs2=%h expected 00001234", out_rs1_val, out_rs2_val); end
        checks++;
        if (obs_bus() !== exp_bus()) begin failures++; $display("FAIL bypass_bus: got %h expected %h", obs_bus(), exp_bus()); end
        idle_side();
        in_valid = 0;
        tick();
        $display("test_bypass done");
    endtask

    task automatic test_load_use();
        idle_side();
        out_ready = 1;
        set_instr(5'd0, 5'd0, 5'd3, 1, 1, 32'h1F0);
        tick();
        set_instr(5'd3, 5'd0, 5'd4, 1, 0, 32'h200);
        tick();
        checks++;
        if (obs_ready !== 1'b0 || out_valid !== 1'b0)
            begin failures++; $display("FAIL load_use_stall1: got ready=%b valid=%b expected 0 0", obs_ready, out_valid); end
        mem_valid = 1; mem_rd_we = 1; mem_is_load = 1; mem_rd = 5'd3; mem_data = 32'hDEAD;
        tick();
        checks++;
        if (obs_ready !== 1'b0 || out_valid !== 1'b0)
            begin failures++; $display("FAIL load_use_stall2: got ready=%b valid=%b expected 0 0", obs_ready, out_valid); end
        idle_side();
        wb_we = 1; wb_rd = 5'd3; wb_data = 32'hCAFE;
        tick();
        checks++;
        if (obs_ready !== 1'b1 || out_valid !== 1'b1 || out_rs1_val !== 32'hCAFE || out_pc !== 32'h200)
            begin failures++; $display("FAIL load_use_issue: got ready=%b valid=%b rs1=%h pc=%h expected 1 1 0000cafe 00000200", obs_ready, out_valid, out_rs1_val, out_pc); end
        checks++;
        if (stall_count !== 16'd2) begin failures++; $display("FAIL load_use_count: got %0d expected 2", stall_count); end
        idle_side();
        $display("test_load_use done");
    endtask

    task automatic test_backpressure();
        idle_side();
        out_ready = 0;
        set_instr(5'd1, 5'd2, 5'd5, 1, 0, 32'h300);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h200 || out_rs1_val !== 32'hCAFE)
                begin failures++; $display("FAIL bp_hold[%0d]: got ready=%b valid=%b pc=%h rs1=%h expected 0 1 00000200 0000cafe", i, obs_ready, out_valid, out_pc, out_rs1_val); end
        end
        out_ready = 1;
        tick();
        checks++;
        if (obs_ready !== 1'b1 || out_valid !== 1'b1 || out_pc !== 32'h300)
            begin failures++; $display("FAIL bp_release: got ready=%b valid=%b pc=%h expected 1 1 00000300", obs_ready, out_valid, out_pc); end
        set_instr(5'd2, 5'd1, 5'd6, 1, 0, 32'h304);
        tick();
        checks++;
        if (out_valid !== 1'b1 || obs_bus() !== exp_bus() || out_pc !== 32'h304)
            begin failures++; $display("FAIL bp_back_to_back: got %h expected %h", obs_bus(), exp_bus()); end
        $display("test_backpressure done");
    endtask

    task automatic test_flush();
        idle_side();
        out_ready = 0;
        flush = 1;
        set_instr(5'd1, 5'd1, 5'd1, 1, 0, 32'h400);
        tick();
        checks++;
        if (obs_ready !== 1'b0 || out_valid !== 1'b0)
            begin failures++; $display("FAIL flush_kill: got ready=%b valid=%b expected 0 0", obs_ready, out_valid); end
        flush = 0;
        out_ready = 1;
        set_instr(5'd0, 5'd0, 5'd6, 1, 1, 32'h500);
        tick();
        set_instr(5'd6, 5'd0, 5'd7, 1, 0, 32'h504);
        flush = 1;
        tick();
        checks++;
        if (stall_count !== 16'd2 || out_valid !== 1'b0)
            begin failures++; $display("FAIL flush_no_count: got count=%0d valid=%b expected 2 0", stall_count, out_valid); end
        flush = 0;
        wb_we = 1; wb_rd = 5'd0; wb_data = 32'hFF;
        mem_valid = 1; mem_rd_we = 1; mem_is_load = 0; mem_rd = 5'd0; mem_data = 32'hEE;
        set_instr(5'd0, 5'd0, 5'd8, 1, 0, 32'h508);
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_rs1_val !== 32'h0 || out_rs2_val !== 32'h0)
            begin failures++; $display("FAIL x0_no_forward: got valid=%b rs1=%h rs2=%h expected 1 0 0", out_valid, out_rs1_val, out_rs2_val); end
        idle_side();
        $display("test_flush done");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_inputs(5);
            tick();
            checks++;
            if (obs_ready !== exp_ready) begin failures++; $display("FAIL rand_ready[%0d]: got %b expected %b", i, obs_ready, exp_ready); end
            checks++;
            if (out_valid !== m_valid) begin failures++; $display("FAIL rand_valid[%0d]: got %b expected %b", i, out_valid, m_valid); end
            checks++;
            if (obs_bus() !== exp_bus()) begin failures++; $display("FAIL rand_bus[%0d]: got %h expected %h", i, obs_bus(), exp_bus()); end
            checks++;
            if (stall_count !== exp_stall()) begin failures++; $display("FAIL rand_count[%0d]: got %h expected %h", i, stall_count, exp_stall()); end
        end
        idle_side();
        in_valid = 0;
        out_ready = 1;
        tick();
        $display("test_random done");
    endtask

    task automatic test_saturation();
        idle_side();
        out_ready = 1;
        mem_valid = 1; mem_rd_we = 1; mem_is_load = 1; mem_rd = 5'd3;
        set_instr(5'd3, 5'd0, 5'd4, 1, 0, 32'h580);
        for (int i = 0; i < 65540; i++) tick();
        checks++;
        if (stall_count !== 16'hFFFF || stall_count !== exp_stall())
            begin failures++; $display("FAIL stall_saturate: got %h expected ffff", stall_count); end
        checks++;
        if (obs_ready !== 1'b0) begin failures++; $display("FAIL saturate_ready: got %b expected 0", obs_ready); end
        idle_side();
        $display("test_saturation done");
    endtask

    task automatic test_async_reset();
        idle_side();
        out_ready = 0;
        set_instr(5'd1, 5'd2, 5'd9, 1, 0, 32'h600);
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h600)
            begin failures++; $display("FAIL pre_reset_full: got valid=%b pc=%h expected 1 00000600", out_valid, out_pc); end
        out_ready = 1;
        #3;
        reset = 0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || stall_count !== 16'd0 || in_ready !== 1'b0 || out_pc !== 32'h0)
            begin failures++; $display("FAIL async_reset: got valid=%b count=%h ready=%b pc=%h expected 0 0 0 0", out_valid, stall_count, in_ready, out_pc); end
        #1;
        reset = 1;
        in_valid = 0;
        reset_model();
        @(posedge clk);
        #1;
        set_instr(5'd1, 5'd0, 5'd9, 1, 0, 32'h700);
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h700 || obs_bus() !== exp_bus())
            begin failures++; $display("FAIL post_reset_issue: got valid=%b bus=%h expected 1 %h", out_valid, obs_bus(), exp_bus()); end
        $display("test_async_reset done");
    endtask

    initial begin
        reset = 0;
        in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_rd_we = 0; in_is_load = 0;
        in_ctrl = 0; in_imm = 0; in_pc = 0; out_ready = 0;
        idle_side();
        for (int i = 0; i < 32; i++) rf_mem[i] = (i == 0) ? 32'd0 : $urandom;
        reset_model();

        test_reset();
        test_rf_path();
        test_bypass();
        test_load_use();
        test_backpressure();
        test_flush();
        test_random();
        test_saturation();
        test_async_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
